// File: rtl/ttt_game_ctrl_if.sv
// Player/board/status bundle for the tic-tac-toe turn controller.
// The controller connects through the slave modport; whoever owns the
// players and the board datapath connects through the master modport.
interface ttt_game_ctrl_if;
  logic       new_game;

  logic       a_req;
  logic [1:0] a_row;
  logic [1:0] a_col;
  logic       a_ack;
  logic       a_nack;

  logic       b_req;
  logic [1:0] b_row;
  logic [1:0] b_col;
  logic       b_ack;
  logic       b_nack;

  logic [8:0] brd_valid;
  logic [1:0] brd_game_state;
  logic       brd_set;
  logic [1:0] brd_row;
  logic [1:0] brd_col;
  logic       brd_reset;

  logic       turn;
  logic       done;
  logic [1:0] result;
  logic [3:0] move_cnt;

  modport master (
    output new_game,
    output a_req, a_row, a_col,
    input  a_ack, a_nack,
    output b_req, b_row, b_col,
    input  b_ack, b_nack,
    output brd_valid, brd_game_state,
    input  brd_set, brd_row, brd_col, brd_reset,
    input  turn, done, result, move_cnt
  );

  modport slave (
    input  new_game,
    input  a_req, a_row, a_col,
    output a_ack, a_nack,
    input  b_req, b_row, b_col,
    output b_ack, b_nack,
    input  brd_valid, brd_game_state,
    output brd_set, brd_row, brd_col, brd_reset,
    output turn, done, result, move_cnt
  );
endinterface

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer and move arbiter.
// Player A (symbol 1) moves first, player B (symbol 0) second. Legal moves
// are acknowledged one cycle after the request, written to the board one
// cycle later (COMMIT), and the board's game_state is sampled one cycle
// after the write (SETTLE) to either pass the turn or end the game.
// Optional turn timeout: define TTT_TURN_TIMEOUT_EN to add the forfeit
// counter and the to_flag output.
module ttt_game_ctrl #(
  parameter int TURN_TIMEOUT = 1000,
  parameter int TO_W         = 10
) (
  input  logic           clk,
  input  logic           reset,
  ttt_game_ctrl_if.slave bus
`ifdef TTT_TURN_TIMEOUT_EN
  ,
  output logic           to_flag
`endif
);

  typedef enum logic [2:0] {
    CLEAR,
    A_TURN,
    B_TURN,
    COMMIT,
    SETTLE,
    OVER
  } state_t;

  state_t     state_q, state_d;
  logic       turn_q, turn_d;
  logic       done_q, done_d;
  logic [1:0] result_q, result_d;
  logic [3:0] moveCnt_q, moveCnt_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic       aAck_q, aAck_d;
  logic       aNack_q, aNack_d;
  logic       bAck_q, bAck_d;
  logic       bNack_q, bNack_d;

  logic       aLegal;
  logic       bLegal;
  logic       movePending;

`ifdef TTT_TURN_TIMEOUT_EN
  logic [TO_W-1:0] toCnt_q, toCnt_d;
  logic            toFlag_q, toFlag_d;
  logic            toExpired;
`endif

  // The timeout counter must be able to represent TURN_TIMEOUT.
  if (TURN_TIMEOUT >= (1 << TO_W)) begin : gToWidthCheck
    $error("TO_W is too narrow for TURN_TIMEOUT");
  end

  // A move is legal when both coordinates are 1..3 and the cell is empty.
  // The occupancy vector is zero-padded so an out-of-range index reads 0.
  function automatic logic moveLegal(input logic [1:0] row,
                                     input logic [1:0] col,
                                     input logic [8:0] occ);
    logic [15:0] occPad;
    logic [3:0]  idx;
    occPad = {7'd0, occ};
    idx    = ({2'd0, row} - 4'd1) * 4'd3 + ({2'd0, col} - 4'd1);
    return (row != 2'd0) && (col != 2'd0) && !occPad[idx];
  endfunction

  assign aLegal      = moveLegal(bus.a_row, bus.a_col, bus.brd_valid);
  assign bLegal      = moveLegal(bus.b_row, bus.b_col, bus.brd_valid);
  // An ack in flight means the turn state is only waiting to enter COMMIT.
  assign movePending = aAck_q | bAck_q;

`ifdef TTT_TURN_TIMEOUT_EN
  assign toExpired = (toCnt_q == TO_W'(TURN_TIMEOUT - 1));
`endif

  // Next-state, arbitration and status update; every request is nacked unless a turn state accepts it.
  always_comb begin
    state_d   = state_q;
    turn_d    = turn_q;
    done_d    = done_q;
    result_d  = result_q;
    moveCnt_d = moveCnt_q;
    row_d     = row_q;
    col_d     = col_q;
    aAck_d    = 1'b0;
    aNack_d   = bus.a_req;
    bAck_d    = 1'b0;
    bNack_d   = bus.b_req;
`ifdef TTT_TURN_TIMEOUT_EN
    toCnt_d   = '0;
    toFlag_d  = 1'b0;
`endif

    if (bus.new_game) begin
      state_d   = CLEAR;
      turn_d    = 1'b0;
      done_d    = 1'b0;
      result_d  = 2'b00;
      moveCnt_d = 4'd0;
    end else begin
      case (state_q)
        CLEAR: begin
          state_d   = A_TURN;
          turn_d    = 1'b0;
          done_d    = 1'b0;
          result_d  = 2'b00;
          moveCnt_d = 4'd0;
        end

        A_TURN, B_TURN: begin
`ifdef TTT_TURN_TIMEOUT_EN
          toCnt_d = toCnt_q + 1'b1;
`endif
          if (movePending) begin
            state_d = COMMIT;
          end else if (state_q == A_TURN) begin
            if (bus.a_req && aLegal) begin
              aAck_d  = 1'b1;
              aNack_d = 1'b0;
              row_d   = bus.a_row;
              col_d   = bus.a_col;
            end
`ifdef TTT_TURN_TIMEOUT_EN
            else if (toExpired) begin
              state_d  = OVER;
              result_d = 2'b10;
              done_d   = 1'b1;
              toFlag_d = 1'b1;
            end
`endif
          end else begin
            if (bus.b_req && bLegal) begin
              bAck_d  = 1'b1;
              bNack_d = 1'b0;
              row_d   = bus.b_row;
              col_d   = bus.b_col;
            end
`ifdef TTT_TURN_TIMEOUT_EN
            else if (toExpired) begin
              state_d  = OVER;
              result_d = 2'b01;
              done_d   = 1'b1;
              toFlag_d = 1'b1;
            end
`endif
          end
        end

        COMMIT: begin
          state_d = SETTLE;
          if (moveCnt_q != 4'd9) begin
            moveCnt_d = moveCnt_q + 4'd1;
          end
        end

        SETTLE: begin
          if (bus.brd_game_state == 2'b00) begin
            turn_d  = ~turn_q;
            state_d = turn_q ? A_TURN : B_TURN;
          end else begin
            result_d = bus.brd_game_state;
            done_d   = 1'b1;
            state_d  = OVER;
          end
        end

        OVER: begin
          state_d = OVER;
        end

        default: begin
          state_d = CLEAR;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset into CLEAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      turn_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 2'b00;
      moveCnt_q <= 4'd0;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      aAck_q    <= 1'b0;
      aNack_q   <= 1'b0;
      bAck_q    <= 1'b0;
      bNack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      turn_q    <= turn_d;
      done_q    <= done_d;
      result_q  <= result_d;
      moveCnt_q <= moveCnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      aAck_q    <= aAck_d;
      aNack_q   <= aNack_d;
      bAck_q    <= bAck_d;
      bNack_q   <= bNack_d;
    end
  end

`ifdef TTT_TURN_TIMEOUT_EN
  // Turn timeout counter and forfeit pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      toCnt_q  <= '0;
      toFlag_q <= 1'b0;
    end else begin
      toCnt_q  <= toCnt_d;
      toFlag_q <= toFlag_d;
    end
  end

  assign to_flag = toFlag_q;
`endif

  assign bus.a_ack     = aAck_q;
  assign bus.a_nack    = aNack_q;
  assign bus.b_ack     = bAck_q;
  assign bus.b_nack    = bNack_q;
  assign bus.brd_reset = (state_q == CLEAR);
  assign bus.brd_set   = (state_q == COMMIT);
  assign bus.brd_row   = row_q;
  assign bus.brd_col   = col_q;
  assign bus.turn      = turn_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.move_cnt  = moveCnt_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Testbench for ttt_game_ctrl: behavioural board, game-level reference
// model, expected-response queues and a monitor that pops them whenever
// the controller pulses ack/nack or writes the board.
module tb_ttt_game_ctrl;

  logic clk = 1'b0;
  logic reset;

  ttt_game_ctrl_if bus();

`ifdef TTT_TURN_TIMEOUT_EN
  logic toFlag;
`endif

  ttt_game_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef TTT_TURN_TIMEOUT_EN
    ,
    .to_flag (toFlag)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cycleCnt   = 0;

  // Cycle counter used to time-stamp expected responses.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  typedef struct {
    bit isAck;
    int cyc;
  } resp_t;

  typedef struct {
    logic [1:0] row;
    logic [1:0] col;
    int         cyc;
  } wr_t;

  resp_t aQ[$];
  resp_t bQ[$];
  wr_t   wQ[$];

  // Win/draw status of a board given occupancy and "cell holds A" vectors.
  function automatic logic [1:0] gameStatus(input logic [8:0] occ, input logic [8:0] isA);
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    for (int l = 0; l < 8; l++) begin
      if (occ[lines[l][0]] && occ[lines[l][1]] && occ[lines[l][2]] &&
          isA[lines[l][0]] == isA[lines[l][1]] && isA[lines[l][1]] == isA[lines[l][2]])
        return isA[lines[l][0]] ? 2'b01 : 2'b10;
    end
    return (&occ) ? 2'b11 : 2'b00;
  endfunction

  // Board datapath stand-in: symbol chosen by occupied-cell parity.
  logic [8:0] boardOcc = '0;
  logic [8:0] boardIsA = '0;

  always @(posedge clk) begin
    if (bus.brd_reset) begin
      boardOcc <= '0;
      boardIsA <= '0;
    end else if (bus.brd_set && bus.brd_row != 2'd0 && bus.brd_col != 2'd0) begin
      boardOcc[(int'(bus.brd_row) - 1) * 3 + int'(bus.brd_col) - 1] <= 1'b1;
      boardIsA[(int'(bus.brd_row) - 1) * 3 + int'(bus.brd_col) - 1] <= ($countones(boardOcc) % 2 == 0);
    end
  end

  assign bus.brd_valid      = boardOcc;
  assign bus.brd_game_state = gameStatus(boardOcc, boardIsA);

  // Reference model of the game, updated when stimulus is issued.
  logic [8:0] refOcc;
  logic [8:0] refIsA;
  bit         refTurn;
  int         refMoves;
  bit         refDone;
  logic [1:0] refResult;

  task automatic refClear();
    refOcc    = '0;
    refIsA    = '0;
    refTurn   = 1'b0;
    refMoves  = 0;
    refDone   = 1'b0;
    refResult = 2'b00;
  endtask

  function automatic bit refLegal(input logic [1:0] row, input logic [1:0] col);
    if (row == 2'd0 || col == 2'd0) return 1'b0;
    return !refOcc[(int'(row) - 1) * 3 + int'(col) - 1];
  endfunction

  task automatic refPlay(input logic [1:0] row, input logic [1:0] col, input int c);
    automatic int idx = (int'(row) - 1) * 3 + int'(col) - 1;
    automatic logic [1:0] st;
    refOcc[idx] = 1'b1;
    refIsA[idx] = (refTurn == 1'b0);
    refMoves++;
    wQ.push_back('{row, col, c + 2});
    st = gameStatus(refOcc, refIsA);
    if (st != 2'b00) begin
      refDone   = 1'b1;
      refResult = st;
    end else begin
      refTurn = ~refTurn;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  task automatic spurious(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got unexpected pulse, expected none (cycle %0d)", name, cycleCnt);
  endtask

  // Monitor: pops expected responses whenever the DUT presents one.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.a_ack || bus.a_nack) begin
          if (aQ.size() == 0) spurious("a_resp");
          else begin
            automatic resp_t r = aQ.pop_front();
            check("a_resp_kind", int'({bus.a_ack, bus.a_nack}), r.isAck ? 2 : 1);
            check("a_resp_cycle", cycleCnt, r.cyc);
          end
        end
        if (bus.b_ack || bus.b_nack) begin
          if (bQ.size() == 0) spurious("b_resp");
          else begin
            automatic resp_t r = bQ.pop_front();
            check("b_resp_kind", int'({bus.b_ack, bus.b_nack}), r.isAck ? 2 : 1);
            check("b_resp_cycle", cycleCnt, r.cyc);
          end
        end
        if (bus.brd_set) begin
          if (wQ.size() == 0) spurious("brd_set");
          else begin
            automatic wr_t w = wQ.pop_front();
            check("brd_row", int'(bus.brd_row), int'(w.row));
            check("brd_col", int'(bus.brd_col), int'(w.col));
            check("brd_set_cycle", cycleCnt, w.cyc);
          end
        end
      end
    end
  end

  task automatic checkOutput();
    check("turn", int'(bus.turn), int'(refTurn));
    check("done", int'(bus.done), int'(refDone));
    check("result", int'(bus.result), int'(refResult));
    check("move_cnt", int'(bus.move_cnt), refMoves);
    check("brd_reset_idle", int'(bus.brd_reset), 0);
  endtask

  // One request slot: drive for one cycle, predict, then wait for the turn to settle.
  task automatic applyStimulus(input bit newGame,
                               input bit aReq, input logic [1:0] aRow, input logic [1:0] aCol,
                               input bit bReq, input logic [1:0] bRow, input logic [1:0] bCol);
    automatic int c;
    automatic bit accA = 1'b0;
    automatic bit accB = 1'b0;
    @(posedge clk);
    #1;
    c = cycleCnt;
    bus.new_game = newGame;
    bus.a_req = aReq; bus.a_row = aRow; bus.a_col = aCol;
    bus.b_req = bReq; bus.b_row = bRow; bus.b_col = bCol;
    if (!newGame && !refDone) begin
      accA = (refTurn == 1'b0) && aReq && refLegal(aRow, aCol);
      accB = (refTurn == 1'b1) && bReq && refLegal(bRow, bCol);
    end
    if (aReq) aQ.push_back('{accA, c + 1});
    if (bReq) bQ.push_back('{accB, c + 1});
    if (accA) refPlay(aRow, aCol, c);
    else if (accB) refPlay(bRow, bCol, c);
    if (newGame) refClear();
    @(posedge clk);
    #1;
    bus.new_game = 1'b0;
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    if (newGame) begin
      check("clear_brd_reset", int'(bus.brd_reset), 1);
      check("clear_move_cnt", int'(bus.move_cnt), 0);
      check("clear_turn", int'(bus.turn), 0);
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic playA(input logic [1:0] r, input logic [1:0] c);
    applyStimulus(1'b0, 1'b1, r, c, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic playB(input logic [1:0] r, input logic [1:0] c);
    applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, r, c);
  endtask

  task automatic newGame();
    applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);
  endtask

  // Random coordinates, mostly aimed at empty cells, occasionally out of range.
  task automatic pickMove(output logic [1:0] r, output logic [1:0] c);
    r = 2'($urandom_range(1, 3));
    c = 2'($urandom_range(1, 3));
    if ($urandom_range(0, 9) == 0) begin
      r = 2'($urandom_range(0, 3));
      c = 2'($urandom_range(0, 3));
    end else begin
      for (int t = 0; t < 8 && !refLegal(r, c); t++) begin
        r = 2'($urandom_range(1, 3));
        c = 2'($urandom_range(1, 3));
      end
    end
  endtask

  initial begin
    automatic int pulses = 0;
    reset = 1'b1;
    bus.new_game = 1'b0;
    bus.a_req = 1'b0; bus.a_row = 2'd0; bus.a_col = 2'd0;
    bus.b_req = 1'b0; bus.b_row = 2'd0; bus.b_col = 2'd0;
    refClear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_brd_reset", int'(bus.brd_reset), 1);
    check("rst_brd_set", int'(bus.brd_set), 0);
    check("rst_brd_row", int'(bus.brd_row), 0);
    check("rst_brd_col", int'(bus.brd_col), 0);
    check("rst_acks", int'({bus.a_ack, bus.a_nack, bus.b_ack, bus.b_nack}), 0);
    check("rst_turn", int'(bus.turn), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_result", int'(bus.result), 0);
    check("rst_move_cnt", int'(bus.move_cnt), 0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      pulses += int'(bus.brd_reset);
    end
    check("brd_reset_pulse_cycles", pulses, 1);
    checkOutput();

    $display("[TB] A wins on the top row");
    playA(2'd1, 2'd1); playB(2'd2, 2'd1); playA(2'd1, 2'd2); playB(2'd2, 2'd2); playA(2'd1, 2'd3);
    check("win_done", int'(bus.done), 1);
    check("win_result", int'(bus.result), 1);
    check("win_move_cnt", int'(bus.move_cnt), 5);

    $display("[TB] illegal and out-of-turn requests");
    newGame();
    playA(2'd1, 2'd1);
    playB(2'd1, 2'd1);
    check("occupied_turn_stays_b", int'(bus.turn), 1);
    playB(2'd2, 2'd2);
    playA(2'd0, 2'd2);
    playB(2'd3, 2'd3);
    applyStimulus(1'b0, 1'b1, 2'd3, 2'd3, 1'b1, 2'd3, 2'd1);
    check("both_req_turn_b", int'(bus.turn), 1);

    $display("[TB] full-board draw");
    newGame();
    playA(2'd1, 2'd1); playB(2'd1, 2'd2); playA(2'd1, 2'd3);
    playB(2'd2, 2'd2); playA(2'd2, 2'd1); playB(2'd2, 2'd3);
    playA(2'd3, 2'd2); playB(2'd3, 2'd1); playA(2'd3, 2'd3);
    check("draw_result", int'(bus.result), 3);
    check("draw_move_cnt", int'(bus.move_cnt), 9);
    playA(2'd1, 2'd1);

    $display("[TB] new_game against a legal request");
    newGame();
    playA(2'd1, 2'd1);
    playB(2'd2, 2'd2);
    applyStimulus(1'b1, 1'b1, 2'd3, 2'd3, 1'b0, 2'd0, 2'd0);

    $display("[TB] randomized games");
    for (int g = 0; g < 15; g++) begin
      newGame();
      for (int s = 0; s < 26; s++) begin
        automatic int pat = $urandom_range(0, 9);
        automatic bit ng = ($urandom_range(0, 49) == 0);
        automatic bit aR = 1'b0;
        automatic bit bR = 1'b0;
        automatic logic [1:0] r1, c1, r2, c2;
        pickMove(r1, c1);
        pickMove(r2, c2);
        if (pat <= 5) begin
          aR = (refTurn == 1'b0);
          bR = (refTurn == 1'b1);
        end else if (pat <= 7) begin
          aR = 1'b1;
          bR = 1'b1;
        end else if (pat == 8) begin
          aR = (refTurn == 1'b1);
          bR = (refTurn == 1'b0);
        end
        applyStimulus(ng, aR, r1, c1, bR, r2, c2);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check("a_queue_drained", aQ.size(), 0);
    check("b_queue_drained", bQ.size(), 0);
    check("w_queue_drained", wQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
Turn sequencer and arbiter for the 3x3 tic-tac-toe board datapath. It accepts move requests from two players (A = symbol 1, moves first; B = symbol 0), validates them against the board's valid vector, and drives the board's set/row/col/reset inputs one move at a time. It reads back the board's game_state to end the game, and reports result and status to the top level.

Parameters:
TURN_TIMEOUT, 1000, cycles a player may hold the turn without a legal move (used only with the optional feature).
TO_W, 10, width of the timeout counter; must satisfy 2^TO_W > TURN_TIMEOUT.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
new_game  in  1  strobe: abort or clear and start a new game
a_req  in  1  player A move strobe
a_row  in  2  player A row, legal 1..3
a_col  in  2  player A col, legal 1..3
a_ack  out  1  1-cycle pulse: A move accepted
a_nack  out  1  1-cycle pulse: A move rejected
b_req, b_row, b_col, b_ack, b_nack  same as A, for player B
brd_valid  in  9  board cell-occupied vector, index (row-1)*3+(col-1)
brd_game_state  in  2  board status: 00 running, 01 A wins, 10 B wins, 11 draw
brd_set  out  1  board write strobe
brd_row  out  2  board row
brd_col  out  2  board col
brd_reset  out  1  board clear
turn  out  1  0 = A to move, 1 = B to move
done  out  1  game over
result  out  2  final outcome, same coding as brd_game_state
move_cnt  out  4  accepted moves this game, 0..9

Behaviour:
- States: CLEAR, A_TURN, B_TURN, COMMIT, SETTLE, OVER.
- Reset: state = CLEAR. Reset values: brd_reset=1, brd_set=0, brd_row=0, brd_col=0, all ack/nack=0, turn=0, done=0, result=00, move_cnt=0.
- CLEAR (1 cycle):
  - brd_reset=1.
  - Next state A_TURN, with turn=0, move_cnt=0, result=00, done=0.
- A_TURN / B_TURN:
  - Only the current player's req is arbitrated.
  - A move is legal when row is in 1..3, col is in 1..3, and brd_valid[idx]==0.
  - Legal move: pulse ack next cycle, latch row/col into brd_row/brd_col, go to COMMIT.
  - Illegal move: pulse nack next cycle, stay in the turn state.
  - A req from the player not on turn always gets nack, including when both requests arrive in the same cycle.
- COMMIT (1 cycle): brd_set=1 with the latched row/col. move_cnt increments; it saturates at 9.
- SETTLE (1 cycle): brd_set=0. Sample brd_game_state:
  - 00: toggle turn and go to the other player's TURN state.
  - Any other value: result = brd_game_state, done=1, go to OVER.
- Move latency: req to ack is 1 cycle. req to brd_set high is 2 cycles. req to next player's turn is 4 cycles.
- Requests in COMMIT, SETTLE or OVER get nack; no state change.
- OVER: result, done, move_cnt and turn hold. Only new_game or reset leaves OVER.
- new_game in any state goes to CLEAR on the next cycle, aborting any in-flight move.
  - If new_game coincides with a legal req, new_game wins and the req gets nack.
  - reset has priority over new_game.
- brd_row/brd_col hold their last value outside COMMIT. brd_set is high only in COMMIT.
- Parity rule: board symbol follows occupied-cell parity. A therefore always fills even move numbers (0,2,..). The controller never skips a turn.

Optional Feature:
Macro TTT_TURN_TIMEOUT_EN.
- With the macro:
  - The TO_W-bit counter clears on entry to A_TURN/B_TURN and increments each cycle in a turn state.
  - When the count reaches TURN_TIMEOUT with no legal move, the player on turn forfeits. result = 10 if A was on turn, 01 if B; done=1; go to OVER.
  - An extra output to_flag (1 bit) pulses for 1 cycle on forfeit; its reset value is 0.
  - A legal req arriving on the timeout cycle wins over the timeout.
- Without the macro: no counter, no to_flag port, and turns wait indefinitely.

Test Plan:
- Reset then idle 5 cycles -> brd_reset=1 for exactly 1 cycle after reset drops; turn=0, done=0, result=00, move_cnt=0.
- A plays (1,1), B (2,1), A (1,2), B (2,2), A (1,3) -> 5 acks; brd_set pulses 2 cycles after each req; done=1, result=01, move_cnt=5.
- A plays (1,1), then B plays (1,1) -> b_nack pulse, turn stays 1. A req (0,2) on A's turn -> a_nack. b_req on A's turn -> b_nack.
- Full-board draw sequence A(1,1) B(1,2) A(1,3) B(2,2) A(2,1) B(2,3) A(3,2) B(3,1) A(3,3) -> result=11, move_cnt=9. A further a_req -> a_nack.
- new_game asserted in the same cycle as a legal a_req mid-game -> a_nack, CLEAR next cycle, move_cnt=0, turn=0.
- With TTT_TURN_TIMEOUT_EN and TURN_TIMEOUT=8: A moves, then B idles -> to_flag pulses 8 cycles after B_TURN entry; result=01, done=1.
